icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameters:
- ICACHE_FRAMES, default 16, number of direct-mapped one-word frames (power of 2).
- LOG_ICACHE_FRAMES, default $clog2(ICACHE_FRAMES), index width.
REQ-002 The block SHALL have these ports:
- CLK  in  1  the single clock.
- nRST  in  1  reset; asynchronous, active-low.
- icache_REN  in  1  fetch read request.
- icache_addr  in  32  fetch byte address; bits 1:0 ignored.
- icache_halt  in  1  fetch halted.
- icache_hit  out  1  icache_load valid this cycle.
- icache_load  out  32  instruction word.
- mem_REN  out  1  memory read request.
- mem_addr  out  32  memory byte address, bits 1:0 = 0.
- mem_wait  in  1  memory busy; low = mem_load valid this cycle.
- mem_load  in  32  memory read data.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

Function
REQ-003 The address split SHALL be: index = icache_addr[LOG_ICACHE_FRAMES+1:2]; tag = icache_addr[31:LOG_ICACHE_FRAMES+2].
REQ-004 Each frame SHALL hold a valid bit, a tag (30-LOG_ICACHE_FRAMES bits) and a 32-bit data word.
REQ-005 The FSM SHALL have two states, IDLE and MISS.
REQ-006 In IDLE, icache_hit SHALL be combinational: icache_REN & ~icache_halt & valid[index] & (tag match); icache_load = data[index] whenever in IDLE. Zero-cycle hit latency.
REQ-007 In IDLE, icache_REN & ~icache_halt & no match SHALL:
- latch icache_addr (bits 1:0 cleared) into miss_addr;
- move to MISS next cycle;
- increment miss_count once.
REQ-008 In MISS, the block SHALL:
- drive mem_REN=1 and mem_addr=miss_addr;
- hold icache_hit=0.
mem_REN SHALL be 0 in IDLE.
REQ-009 In MISS with mem_wait=0, the block SHALL write frame[miss_addr index] = {valid=1, miss_addr tag, mem_load} at the clock edge and return to IDLE. The refetched address then hits one cycle later (fill-to-hit latency 1); there is no fill bypass.
REQ-010 Changes to icache_addr or icache_REN during MISS SHALL NOT affect the fill, which uses miss_addr only. After the fill, IDLE re-evaluates the current icache_addr, so a redirected fetch may immediately start a new miss.
REQ-011 icache_halt SHALL:
- force icache_hit=0;
- block entry to MISS.
A miss already in progress SHALL still complete its fill.
REQ-012 hit_count SHALL increment on every cycle icache_hit=1. Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-013 A fill SHALL overwrite the existing frame unconditionally (conflict eviction). The block has no write path and no invalidation other than reset.
REQ-014 When icache_REN=0 in IDLE, the block SHALL:
- hold all state;
- drive icache_hit=0;
- leave counters unchanged.

Reset
REQ-015 nRST low SHALL asynchronously set:
- state=IDLE;
- all valid bits=0, all tags=0, all data=0;
- miss_addr=0;
- hit_count=0, miss_count=0.
Resulting outputs: mem_REN=0, mem_addr=0, icache_hit=0.
REQ-016 Reset asserted during MISS SHALL abort the miss: no frame is written and mem_REN drops immediately.

Verification
REQ-017 Cold miss then hit: REN=1, addr=0x40, memory returns 0x8C220004 after 3 wait cycles -> mem_REN=1 with mem_addr=0x40 for 4 cycles, then IDLE; next cycle icache_hit=1, icache_load=0x8C220004; hit_count=1, miss_count=1.
REQ-018 Conflict eviction (16 frames): fill 0x40, then fill 0x80 (same index 0) -> a subsequent read of 0x40 misses again; miss_count=3.
REQ-019 Redirect during miss: miss on 0x100, change addr to 0x200 while mem_wait=1 -> fill goes to 0x100; next cycle 0x200 misses with mem_addr=0x200.
REQ-020 Halt: cached 0x40, icache_halt=1 with REN=1 -> icache_hit=0 and hit_count frozen; halt asserted on an uncached address -> no mem_REN.
REQ-021 Reset mid-miss: nRST low while in MISS -> mem_REN=0 immediately; after release, read of the same address misses again and all counters are 0.
REQ-022 Saturation: force hit_count to 0xFFFFFFFE, issue 3 hits -> hit_count=0xFFFFFFFF.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// slave  : cache view (takes fetch requests and memory data, returns
//          hit/instruction, memory request and the hit/miss counters).
// master : environment view (fetch unit + memory model), the mirror image.
interface icache_if;
  logic        icache_REN;
  logic [31:0] icache_addr;
  logic        icache_halt;
  logic        icache_hit;
  logic [31:0] icache_load;
  logic        mem_REN;
  logic [31:0] mem_addr;
  logic        mem_wait;
  logic [31:0] mem_load;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  icache_REN, icache_addr, icache_halt, mem_wait, mem_load,
    output icache_hit, icache_load, mem_REN, mem_addr, hit_count, miss_count
  );

  modport master (
    output icache_REN, icache_addr, icache_halt, mem_wait, mem_load,
    input  icache_hit, icache_load, mem_REN, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking
// refill from memory and saturating hit/miss counters.
// Ports:
//   CLK   - clock
//   nRST  - asynchronous active-low reset
//   bus   - icache_if.slave: fetch request (REN/addr/halt), hit and
//           instruction word, memory read request/address/wait/data,
//           hit_count and miss_count.
// Hits are answered combinationally in IDLE; a miss latches the word
// address and sits in MISS until memory drops mem_wait, then fills the
// frame and returns to IDLE (the refetched word hits the following cycle).
module icache #(
  parameter int unsigned ICACHE_FRAMES     = 16,
  parameter int unsigned LOG_ICACHE_FRAMES = $clog2(ICACHE_FRAMES)
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);

  localparam int unsigned TAG_W = 30 - LOG_ICACHE_FRAMES;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [ICACHE_FRAMES-1:0]     valid_q;
  logic [TAG_W-1:0]             tag_q  [ICACHE_FRAMES];
  logic [31:0]                  data_q [ICACHE_FRAMES];
  logic [31:0]                  miss_addr_q, miss_addr_d;
  logic [31:0]                  hit_count_q, hit_count_d;
  logic [31:0]                  miss_count_q, miss_count_d;

  logic [LOG_ICACHE_FRAMES-1:0] req_idx_c, fill_idx_c;
  logic [TAG_W-1:0]             req_tag_c, fill_tag_c;
  logic                         match_c, lookup_c, hit_c, miss_start_c, fill_c;
  logic [1:0]                   addr_lsb_unused;

  // Address split for the live request and for the latched miss.
  assign req_idx_c       = bus.icache_addr[LOG_ICACHE_FRAMES+1:2];
  assign req_tag_c       = bus.icache_addr[31:LOG_ICACHE_FRAMES+2];
  assign fill_idx_c      = miss_addr_q[LOG_ICACHE_FRAMES+1:2];
  assign fill_tag_c      = miss_addr_q[31:LOG_ICACHE_FRAMES+2];
  assign addr_lsb_unused = bus.icache_addr[1:0];

  // Lookup only happens for an un-halted request while idle.
  assign match_c      = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
  assign lookup_c     = (state_q == IDLE) && bus.icache_REN && !bus.icache_halt;
  assign hit_c        = lookup_c && match_c;
  assign miss_start_c = lookup_c && !match_c;
  assign fill_c       = (state_q == MISS) && !bus.mem_wait;

  // Outputs: hit is zero-latency by design; memory side follows the FSM.
  assign bus.icache_hit  = hit_c;
  assign bus.icache_load = (state_q == IDLE) ? data_q[req_idx_c] : 32'h0;
  assign bus.mem_REN     = (state_q == MISS);
  assign bus.mem_addr    = miss_addr_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;

  // Next-state, miss address capture and saturating counters.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    case (state_q)
      IDLE: begin
        if (miss_start_c) begin
          state_d     = MISS;
          miss_addr_d = {bus.icache_addr[31:2], 2'b00};
        end
      end
      MISS: begin
        // The fill uses miss_addr only; fetch-side changes are ignored here.
        if (!bus.mem_wait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hit_c && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start_c && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  // State, frames and counters; reset aborts any miss without a fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= 32'h0;
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
      for (int i = 0; i < int'(ICACHE_FRAMES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      // Unconditional overwrite: conflicting lines simply evict each other.
      if (fill_c) begin
        valid_q[fill_idx_c] <= 1'b1;
        tag_q[fill_idx_c]   <= fill_tag_c;
        data_q[fill_idx_c]  <= bus.mem_load;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized
// fetch stream, compared against a frame-table model of the cache.
module tb_icache;

  logic CLK;
  logic nRST;

  icache_if bus ();

  icache #(.ICACHE_FRAMES(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: which word address each frame holds, and its data.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  int checks;
  int errors;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_word[i]  = 30'h0;
      m_data[i]  = 32'h0;
    end
    exp_hits   = 32'h0;
    exp_misses = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hit_count"},  bus.hit_count,  exp_hits);
    check({tag, "_miss_count"}, bus.miss_count, exp_misses);
  endtask

  // One fetch starting at posedge+1; on a miss, memory answers after
  // 'waits' busy cycles. During the miss the fetch side may be redirected
  // to 'redir' and/or halted. Returns at posedge+1 with REN low.
  task automatic fetch(input logic [31:0] a, input int unsigned waits,
                       input logic [31:0] data, input logic [31:0] redir,
                       input bit halt_mid);
    int idx;
    bit exp_hit;
    int ren_cycles;
    idx     = int'(a[5:2]);
    exp_hit = m_valid[idx] && (m_word[idx] == a[31:2]);
    bus.icache_REN  = 1'b1;
    bus.icache_addr = a;
    bus.icache_halt = 1'b0;
    @(negedge CLK);
    check("hit", 32'(bus.icache_hit), 32'(exp_hit));
    check("mem_REN_idle", 32'(bus.mem_REN), 32'd0);
    if (exp_hit) check("load", bus.icache_load, m_data[idx]);
    @(posedge CLK); #1;
    if (exp_hit) begin
      exp_hits = sat_inc(exp_hits);
    end else begin
      exp_misses = sat_inc(exp_misses);
      ren_cycles = 0;
      for (int k = 0; k <= int'(waits); k++) begin
        bus.mem_wait    = (k < int'(waits));
        bus.mem_load    = (k < int'(waits)) ? $urandom : data;
        bus.icache_addr = redir;
        bus.icache_halt = halt_mid;
        @(negedge CLK);
        if (bus.mem_REN === 1'b1) ren_cycles++;
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        check("hit_in_miss", 32'(bus.icache_hit), 32'd0);
        @(posedge CLK); #1;
      end
      check("mem_REN_cycles", 32'(ren_cycles), 32'(waits + 1));
      m_valid[idx] = 1'b1;
      m_word[idx]  = a[31:2];
      m_data[idx]  = data;
      bus.mem_wait    = 1'b1;
      bus.icache_halt = 1'b0;
    end
    bus.icache_REN = 1'b0;
    check_counts("fetch");
  endtask

  // Halted request: never hits, never starts a miss, counters frozen.
  task automatic halt_probe(input logic [31:0] a);
    bus.icache_REN  = 1'b1;
    bus.icache_addr = a;
    bus.icache_halt = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("halt_hit", 32'(bus.icache_hit), 32'd0);
      check("halt_mem_REN", 32'(bus.mem_REN), 32'd0);
      @(posedge CLK); #1;
    end
    bus.icache_halt = 1'b0;
    bus.icache_REN  = 1'b0;
    check_counts("halt");
  endtask

  // No request: no hit and nothing changes.
  task automatic idle_cycle(input logic [31:0] a);
    bus.icache_REN  = 1'b0;
    bus.icache_addr = a;
    @(negedge CLK);
    check("idle_hit", 32'(bus.icache_hit), 32'd0);
    check("idle_mem_REN", 32'(bus.mem_REN), 32'd0);
    @(posedge CLK); #1;
    check_counts("idle");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    int unsigned op;
    checks = 0;
    errors = 0;
    model_reset();
    nRST            = 1'b0;
    bus.icache_REN  = 1'b0;
    bus.icache_addr = 32'h0;
    bus.icache_halt = 1'b0;
    bus.mem_wait    = 1'b1;
    bus.mem_load    = 32'h0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_mem_REN", 32'(bus.mem_REN), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_hit", 32'(bus.icache_hit), 32'd0);
    check_counts("rst");
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Reset frames are invalid even though tag/data are zero.
    fetch(32'h0000_0000, 0, 32'h1111_2222, 32'h0, 1'b0);

    // Cold miss then hit.
    fetch(32'h0000_0040, 3, 32'h8C22_0004, 32'h0000_0040, 1'b0);
    fetch(32'h0000_0040, 0, 32'h0, 32'h0000_0040, 1'b0);
    check("cold_hit_count", bus.hit_count, 32'd1);
    check("cold_miss_count", bus.miss_count, 32'd2);

    // Conflict eviction: 0x80 shares frame 0 with 0x40.
    fetch(32'h0000_0080, 1, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0);
    fetch(32'h0000_0040, 0, 32'h8C22_0004, 32'h0000_0040, 1'b0);
    check("evict_miss_count", bus.miss_count, 32'd4);

    // Redirect during a miss: fill stays with 0x104, 0x208 then misses.
    fetch(32'h0000_0104, 2, 32'hA0A0_0104, 32'h0000_0208, 1'b0);
    fetch(32'h0000_0208, 1, 32'hB0B0_0208, 32'h0000_0208, 1'b0);
    fetch(32'h0000_0104, 0, 32'h0, 32'h0000_0104, 1'b0);

    // Halt on cached and uncached addresses; halt during a miss.
    halt_probe(32'h0000_0040);
    halt_probe(32'h0000_3000);
    fetch(32'h0000_3004, 2, 32'hC0DE_3004, 32'h0000_3004, 1'b1);
    fetch(32'h0000_3004, 0, 32'h0, 32'h0000_3004, 1'b0);

    // Randomized stream over a small address set to exercise hits/conflicts.
    for (int n = 0; n < 200; n++) begin
      a  = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_0000;
      op = $urandom_range(0, 9);
      r  = 32'($urandom_range(0, 63)) << 2;
      case (op)
        0:       idle_cycle(a);
        1:       halt_probe(a);
        2:       fetch(a, $urandom_range(0, 3), $urandom, r, 1'($urandom_range(0, 1)));
        default: fetch(a, $urandom_range(0, 3), $urandom, a, 1'b0);
      endcase
    end

    // Reset in the middle of a miss.
    bus.icache_REN  = 1'b1;
    bus.icache_addr = 32'h0000_ABC0;
    bus.mem_wait    = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rmiss_mem_REN_before", 32'(bus.mem_REN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rmiss_mem_REN_after", 32'(bus.mem_REN), 32'd0);
    model_reset();
    check_counts("rmiss");
    bus.icache_REN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    fetch(32'h0000_ABC0, 1, 32'h5555_ABC0, 32'h0000_ABC0, 1'b0);
    check("rmiss_refetch_misses", bus.miss_count, 32'd1);

    // Hit counter saturation.
    fetch(32'h0000_0040, 1, 32'h8C22_0004, 32'h0000_0040, 1'b0);
    force dut.hit_count_q = 32'hFFFF_FFFE;
    @(posedge CLK); #1;
    release dut.hit_count_q;
    exp_hits = 32'hFFFF_FFFE;
    check_counts("sat_forced");
    repeat (3) fetch(32'h0000_0040, 0, 32'h0, 32'h0000_0040, 1'b0);
    check("sat_hit_count", bus.hit_count, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
